// File: rtl/sdram_sweep_tester.sv
// sdram_sweep_tester: write/readback sweep self-test on the az_*/za_* controller bus (clk/reset; start,base_addr,len,seed in; busy,done,pass,err_count,first_err_addr out; az_* requests out, za_* responses in)
module sdram_sweep_tester #(
  parameter int ADDR_W   = 22,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              az_cs,
  output logic              az_rd_n,
  output logic              az_wr_n,
  output logic [1:0]        az_be_n,
  output logic [ADDR_W-1:0] az_addr,
  output logic [DATA_W-1:0] az_data,
  input  logic              za_wait,
  input  logic              za_valid,
  input  logic [DATA_W-1:0] za_data
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  localparam logic [3:0] MP = 4'(MAX_PEND);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, len_q, len_d, idx_q, idx_d, ridx_q, ridx_d, ferr_q, ferr_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [3:0] pend_q, pend_d;
  logic [15:0] err_q, err_d;
  logic pass_q, pass_d;
  logic [ADDR_W-1:0] req_addr, rd_addr;
  logic wr_req, rd_req, wr_acc, rd_acc, last, vld, miss;
  assign req_addr = base_q + idx_q;
  assign rd_addr = base_q + ridx_q;
  assign wr_req = state_q == WRITE;
  assign rd_req = state_q == READ && pend_q < MP;
  assign wr_acc = wr_req && !za_wait;
  assign rd_acc = rd_req && !za_wait;
  assign last = idx_q == len_q - 1'b1;
  // returned data is only meaningful while reads are outstanding
  assign vld = za_valid && pend_q != 4'd0;
  assign miss = vld && za_data != (DATA_W'(rd_addr) ^ seed_q);
  assign az_cs = 1'b1;
  assign az_be_n = 2'b00;
  assign az_wr_n = !wr_req;
  assign az_rd_n = !rd_req;
  assign az_addr = (wr_req || rd_req) ? req_addr : '0;
  assign az_data = wr_req ? (DATA_W'(req_addr) ^ seed_q) : '0;
  assign busy = state_q == WRITE || state_q == READ || state_q == DRAIN;
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign err_count = err_q;
  assign first_err_addr = ferr_q;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    len_d = len_q;
    seed_d = seed_q;
    idx_d = idx_q;
    ridx_d = vld ? ridx_q + 1'b1 : ridx_q;
    pend_d = pend_q + {3'b0, rd_acc} - {3'b0, vld};
    err_d = (miss && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    ferr_d = (miss && err_q == 16'd0) ? rd_addr : ferr_q;
    pass_d = pass_q;
    unique case (state_q)
      IDLE: if (start) begin
        base_d = base_addr;
        len_d = len;
        seed_d = seed;
        idx_d = '0;
        ridx_d = '0;
        err_d = '0;
        ferr_d = '0;
        pass_d = len == '0;
        state_d = len == '0 ? DONE : WRITE;
      end
      WRITE: if (wr_acc) begin
        idx_d = last ? '0 : idx_q + 1'b1;
        state_d = last ? READ : WRITE;
      end
      READ: if (rd_acc) begin
        idx_d = idx_q + 1'b1;
        state_d = last ? DRAIN : READ;
      end
      DRAIN: if (pend_q == 4'd0) begin
        state_d = DONE;
        pass_d = err_q == 16'd0;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q <= '0;
      len_q <= '0;
      seed_q <= '0;
      idx_q <= '0;
      ridx_q <= '0;
      pend_q <= '0;
      err_q <= '0;
      ferr_q <= '0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      len_q <= len_d;
      seed_q <= seed_d;
      idx_q <= idx_d;
      ridx_q <= ridx_d;
      pend_q <= pend_d;
      err_q <= err_d;
      ferr_q <= ferr_d;
      pass_q <= pass_d;
    end
  end
endmodule

// File: tb/tb_sdram_sweep_tester.sv
// tb_sdram_sweep_tester: randomized sweeps against a behavioural memory/controller model
module tb_sdram_sweep_tester;
  localparam int AW = 22;
  localparam int MP = 4;
  logic clk = 0, reset = 1, start = 0;
  logic [AW-1:0] base_addr = '0, len = '0;
  logic [15:0] seed = '0;
  logic busy, done, pass, az_cs, az_rd_n, az_wr_n;
  logic [15:0] err_count, az_data;
  logic [AW-1:0] first_err_addr, az_addr;
  logic [1:0] az_be_n;
  logic za_wait = 0, za_valid = 0;
  logic [15:0] za_data = '0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  sdram_sweep_tester #(.ADDR_W(AW), .DATA_W(16), .MAX_PEND(MP)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
    .az_cs(az_cs), .az_rd_n(az_rd_n), .az_wr_n(az_wr_n), .az_be_n(az_be_n), .az_addr(az_addr),
    .az_data(az_data), .za_wait(za_wait), .za_valid(za_valid), .za_data(za_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory/controller model state
  typedef struct { int due; logic [15:0] d; } rd_t;
  rd_t rq[$];
  logic [15:0] mem [logic [AW-1:0]];
  logic [AW-1:0] wr_log[$], rd_log[$], corrupt_addr = '0;
  logic [15:0] wd_log[$];
  int lat = 2, wait_pct = 0, burst_left = 0, outstanding = 0, max_out = 0, cyc = 0;
  bit burst_arm = 0, corrupt_en = 0, noise = 0;

  initial begin : model
    logic [15:0] d;
    logic [AW-1:0] st_addr;
    logic [15:0] st_data;
    logic [1:0] st_rw;
    bit stalled;
    int out_prev;
    rd_t e;
    stalled = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        rq.delete();
        outstanding = 0;
        stalled = 0;
        burst_left = 0;
        za_wait = 0;
        za_valid = 0;
      end else begin
        if (stalled) begin
          chk("stall_addr", az_addr, st_addr);
          chk("stall_data", az_data, st_data);
          chk("stall_rw", {az_rd_n, az_wr_n}, st_rw);
        end
        if (burst_arm && !az_wr_n && wr_log.size() == 1) begin
          burst_arm = 0;
          burst_left = 3;
        end
        if (burst_left > 0) begin
          za_wait = 1;
          burst_left--;
        end else za_wait = $urandom_range(99) < wait_pct;
        stalled = (!az_rd_n || !az_wr_n) && za_wait;
        st_addr = az_addr;
        st_data = az_data;
        st_rw = {az_rd_n, az_wr_n};
        out_prev = outstanding;
        if (!az_rd_n || !az_wr_n) chk("rd_wr_excl", az_rd_n ^ az_wr_n, 1);
        if (!za_wait && !az_wr_n) begin
          mem[az_addr] = az_data;
          wr_log.push_back(az_addr);
          wd_log.push_back(az_data);
        end
        if (!za_wait && !az_rd_n) begin
          d = mem.exists(az_addr) ? mem[az_addr] : 16'hDEAD;
          if (corrupt_en && az_addr == corrupt_addr) d = d ^ 16'h0100;
          e.due = cyc + lat;
          e.d = d;
          rq.push_back(e);
          rd_log.push_back(az_addr);
          outstanding++;
        end
        za_valid = 0;
        za_data = 16'($urandom);
        if (rq.size() > 0 && rq[0].due <= cyc) begin
          za_valid = 1;
          za_data = rq[0].d;
          rq.pop_front();
          outstanding--;
        end else if (noise && out_prev == 0) za_valid = $urandom_range(3) == 0;
        if (outstanding > max_out) max_out = outstanding;
      end
    end
  end

  task automatic sweep(input logic [AW-1:0] b, input logic [AW-1:0] n, input logic [15:0] s);
    int cnt, ecnt;
    logic [AW-1:0] a, efirst;
    ecnt = 0;
    efirst = '0;
    for (int i = 0; i < int'(n); i++) begin
      a = b + AW'(i);
      if (corrupt_en && a == corrupt_addr) begin
        if (ecnt == 0) efirst = a;
        ecnt++;
      end
    end
    wr_log.delete();
    wd_log.delete();
    rd_log.delete();
    max_out = 0;
    base_addr = b;
    len = n;
    seed = s;
    start = 1;
    @(posedge clk);
    #2 start = 0;
    chk("busy_after_start", busy, n != 0);
    cnt = 0;
    while (!done && cnt < 3000) begin
      @(posedge clk);
      #2 cnt++;
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    chk("pass", pass, ecnt == 0);
    chk("err_count", err_count, ecnt);
    chk("first_err_addr", first_err_addr, efirst);
    chk("write_count", wr_log.size(), n);
    chk("read_count", rd_log.size(), n);
    chk("max_pending", max_out <= MP, 1);
    for (int i = 0; i < int'(n) && i < wr_log.size() && i < rd_log.size(); i++) begin
      a = b + AW'(i);
      chk("wr_addr", wr_log[i], a);
      chk("wr_data", wd_log[i], a[15:0] ^ s);
      chk("rd_addr", rd_log[i], a);
    end
    @(posedge clk);
    #2;
    chk("done_pulse", done, 0);
    chk("pass_hold", pass, ecnt == 0);
    chk("err_hold", err_count, ecnt);
  endtask

  initial begin
    int cnt;
    logic [AW-1:0] b, n;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ferr", first_err_addr, 0);
    chk("rst_rw", {az_rd_n, az_wr_n}, 2'b11);
    chk("rst_addr", az_addr, 0);
    chk("rst_data", az_data, 0);
    chk("cs_be", {az_cs, az_be_n}, 3'b100);
    reset = 0;
    sweep(22'h10, 4, 16'hA5A5);
    burst_arm = 1;
    sweep(22'h10, 4, 16'hA5A5);
    chk("burst_used", burst_arm, 0);
    corrupt_en = 1;
    corrupt_addr = 22'h12;
    sweep(22'h10, 4, 16'hA5A5);
    corrupt_en = 0;
    sweep(22'h3FFFFE, 4, 16'h1234);
    lat = 8;
    sweep(22'h100, 16, 16'h5A5A);
    chk("pend_reached_max", max_out, MP);
    noise = 1;
    for (int k = 0; k < 12; k++) begin
      lat = $urandom_range(1, 8);
      wait_pct = $urandom_range(0, 40);
      b = k[0] ? AW'(22'h3FFFF0 + $urandom_range(15)) : AW'($urandom);
      n = AW'($urandom_range(1, 20));
      corrupt_en = $urandom_range(1) == 1;
      corrupt_addr = b + AW'($urandom_range(0, 24));
      sweep(b, n, 16'($urandom));
    end
    corrupt_en = 0;
    wait_pct = 0;
    sweep(22'h55, 0, 16'h7777);
    lat = 8;
    wr_log.delete();
    rd_log.delete();
    base_addr = 22'h200;
    len = 16;
    seed = 16'h0F0F;
    start = 1;
    @(posedge clk);
    #2 start = 0;
    cnt = 0;
    while (rd_log.size() < 2 && cnt < 500) begin
      @(posedge clk);
      #2 cnt++;
    end
    chk("reached_read", rd_log.size() >= 2, 1);
    reset = 1;
    @(posedge clk);
    #2;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pass", pass, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_ferr", first_err_addr, 0);
    chk("mid_rst_rw", {az_rd_n, az_wr_n}, 2'b11);
    chk("mid_rst_addr", az_addr, 0);
    chk("mid_rst_data", az_data, 0);
    reset = 0;
    @(posedge clk);
    #2;
    sweep(22'h0, 0, 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
